hazard_scoreboard: RTL

- Parametrised, stateful successor to the combinational decode-stage hazard detector.
- Keeps a per-register countdown scoreboard of pending writebacks and raises the stall request for the ID stage.
- Supports configurable pipeline writeback latency, variable load latency and a forwarding/no-forwarding mode.
- Freezes with the pipeline on memory stalls and keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_scoreboard.sv | 96 +++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Decode-stage hazard detector built on a per-register countdown scoreboard.
//   Each destination register carries a counter holding the number of further
//   issue cycles a reader of that register must stall. Producers load the
//   counter on issue. The value loaded depends on the forwarding mode and on
//   whether the producer is a load. Counters count down to zero. The whole
//   scoreboard holds while the pipeline is frozen.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   id_valid       ID stage holds a real instruction
//   rn, rdm        source registers (rdm only when two_src=1)
//   dest, wb_en    destination register and its write enable
//   mem_r_en       ID instruction is a load
//   forward_en     forwarding mode for instructions issuing this cycle
//   flush          ID instruction squashed (no hazard, no issue)
//   freeze         memory stall; scoreboard and counter hold
//   hazard         combinational stall request for IF/ID
//   busy_vec       registered per-register "counter nonzero" flags
//   stall_cnt      saturating count of unfrozen cycles with hazard=1
module hazard_scoreboard #(
  parameter int REG_AW   = 4,
  parameter int WB_LAT   = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [REG_AW-1:0]      rn,
  input  logic [REG_AW-1:0]      rdm,
  input  logic                   two_src,
  input  logic [REG_AW-1:0]      dest,
  input  logic                   wb_en,
  input  logic                   mem_r_en,
  input  logic                   forward_en,
  input  logic                   flush,
  input  logic                   freeze,
  output logic                   hazard,
  output logic [2**REG_AW-1:0]   busy_vec,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int NREG   = 2**REG_AW;
  localparam int MAXLAT = (WB_LAT > LOAD_LAT) ? WB_LAT : LOAD_LAT;
  localparam int CW     = (MAXLAT < 1) ? 1 : $clog2(MAXLAT + 1);

  logic [CW-1:0] cnt     [NREG];
  logic [CW-1:0] cnt_nxt [NREG];
  logic [CW-1:0] load_val;
  logic          issue;

  always_comb begin
    hazard = id_valid & ~flush &
             ((cnt[rn] != '0) | (two_src & (cnt[rdm] != '0)));
    issue  = id_valid & ~flush & ~hazard & ~freeze;
  end

  always_comb begin
    if (!forward_en)
      load_val = CW'(WB_LAT);
    else if (mem_r_en)
      load_val = CW'(LOAD_LAT);
    else
      load_val = '0;
  end

  // A new producer overwrites the running count rather than taking the max:
  // with in-order issue the youngest writer is the one that matters.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      cnt_nxt[i] = cnt[i];
      if (issue && wb_en && (dest == REG_AW'(i)))
        cnt_nxt[i] = load_val;
      else if (cnt[i] != '0)
        cnt_nxt[i] = cnt[i] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++)
        cnt[i] <= '0;
      busy_vec  <= '0;
      stall_cnt <= '0;
    end else if (!freeze) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt[i]      <= cnt_nxt[i];
        busy_vec[i] <= (cnt_nxt[i] != '0);
      end
      if (hazard && !(&stall_cnt))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
